// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the cpu pipeline (opcodes, functs, ALU control, forward selects).
// CPU_MUL_EN adds the mul decode; otherwise that encoding is treated as a nop.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // Any encoding outside the supported subset yields all-zero controls, i.e. a nop.
  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t      c;
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
    c  = '0;
    f3 = instr[14:12];
    f7 = instr[31:25];
    case (instr[6:0])
      OP_R: begin
        ok = (f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_SLL || f3 == F3_XOR || f3 == F3_AND))
          || (f7 == F7_ALT && f3 == F3_ADD);
`ifdef CPU_MUL_EN
        ok = ok || (f7 == F7_MULDIV && f3 == F3_ADD);
`endif
        if (ok) begin
          c.reg_write = 1'b1;
          c.alu_op    = ALUOP_RTYPE;
        end
      end
      OP_I: begin
        if (f3 == F3_ADD || (f3 == F3_SR && f7 == F7_ALT)) begin
          c.reg_write = 1'b1;
          c.alu_src   = 1'b1;
          c.alu_op    = ALUOP_ITYPE;
        end
      end
      OP_LOAD: begin
        if (f3 == F3_LW) begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          c.mem_read   = 1'b1;
          c.alu_src    = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3 == F3_LW) begin
          c.mem_write = 1'b1;
          c.alu_src   = 1'b1;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic alu_ctrl_e alu_decode(input alu_op_e op, input logic [2:0] f3,
                                           input logic [6:0] f7);
    alu_ctrl_e a;
    a = ALU_ADD;
    case (op)
      ALUOP_SUB:   a = ALU_SUB;
      ALUOP_ITYPE: a = (f3 == F3_SR) ? ALU_SRA : ALU_ADD;
      ALUOP_RTYPE: begin
        case (f3)
          F3_SLL: a = ALU_SLL;
          F3_XOR: a = ALU_XOR;
          F3_AND: a = ALU_AND;
          default: begin
`ifdef CPU_MUL_EN
            if (f7 == F7_MULDIV)  a = ALU_MUL;
            else if (f7 == F7_ALT) a = ALU_SUB;
            else                   a = ALU_ADD;
`else
            a = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
`endif
          end
        endcase
      end
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cpu_hazard_forward_unit.sv
// cpu_hazard_forward_unit: load-use stall detection and EX-stage operand forward selection.
module cpu_hazard_forward_unit
  import cpu_pkg::*;
(
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rd,
  input  logic [4:0] i_idex_rs1,
  input  logic [4:0] i_idex_rs2,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_exmem_reg_write,
  input  logic [4:0] i_exmem_rd,
  input  logic       i_memwb_reg_write,
  input  logic [4:0] i_memwb_rd,
  output logic       o_stall,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);

  logic w_exmem_valid;
  logic w_memwb_valid;

  assign w_exmem_valid = i_exmem_reg_write && (i_exmem_rd != 5'd0);
  assign w_memwb_valid = i_memwb_reg_write && (i_memwb_rd != 5'd0);

  assign o_stall = i_idex_mem_read && (i_idex_rd != 5'd0)
                && ((i_idex_rd == i_id_rs1) || (i_idex_rd == i_id_rs2));

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    o_fwd_a = FWD_NONE;
    o_fwd_b = FWD_NONE;
    if (w_exmem_valid && i_exmem_rd == i_idex_rs1)      o_fwd_a = FWD_EXMEM;
    else if (w_memwb_valid && i_memwb_rd == i_idex_rs1) o_fwd_a = FWD_MEMWB;
    if (w_exmem_valid && i_exmem_rd == i_idex_rs2)      o_fwd_b = FWD_EXMEM;
    else if (w_memwb_valid && i_memwb_rd == i_idex_rs2) o_fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/cpu.sv
// cpu: five-stage in-order RV32 pipeline (IF/ID/EX/MEM/WB) with imem, dmem and register file.
// Define CPU_MUL_EN to add the mul instruction and its multiplier.
module cpu
  import cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);

  logic [31:0] w_pc, w_pc_plus4, w_if_instr;
  logic [31:0] r_ifid_pc, r_ifid_instr;
  ctrl_t       w_id_ctrl;
  logic [4:0]  w_id_rs1, w_id_rs2;
  logic [31:0] w_id_imm, w_br_imm, w_br_target, w_rd1, w_rd2;
  logic        w_id_is_beq, w_branch_taken, w_stall;
  ctrl_t       r_idex_ctrl;
  logic [31:0] r_idex_rd1, r_idex_rd2, r_idex_imm;
  logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
  logic [2:0]  r_idex_funct3;
  logic [6:0]  r_idex_funct7;
  logic [1:0]  w_fwd_a, w_fwd_b;
  logic [31:0] w_op_a, w_op_b, w_alu_b, w_alu_result;
  alu_ctrl_e   w_alu_ctrl;
  logic        r_exmem_reg_write, r_exmem_mem_to_reg, r_exmem_mem_write;
  logic [31:0] r_exmem_alu, r_exmem_store, w_mem_rdata;
  logic [4:0]  r_exmem_rd;
  logic        r_memwb_reg_write, r_memwb_mem_to_reg;
  logic [31:0] r_memwb_alu, r_memwb_mem_data, w_wb_data;
  logic [4:0]  r_memwb_rd;
  logic        w_wb_writes;

  if (1'b1) begin : PC
    logic [31:0] pc_o;
    // NOTE: synchronous reset inside the clocked block, and state always updated with <=.
    always_ff @(posedge clk_i) begin
      if (rst_i)                  pc_o <= '0;
      else if (start_i && !w_stall) pc_o <= w_branch_taken ? w_br_target : w_pc_plus4;
    end
  end

  if (1'b1) begin : Instruction_Memory
    logic [31:0] memory [256];
  end

  if (1'b1) begin : Data_Memory
    logic [31:0] memory [32];
    // NOTE: storage arrays have no reset; contents survive rst_i and only the pipeline clears.
    always_ff @(posedge clk_i) begin
      if (!rst_i && start_i && r_exmem_mem_write) memory[r_exmem_alu[6:2]] <= r_exmem_store;
    end
  end

  if (1'b1) begin : Registers
    logic [31:0] register [32];
    always_ff @(posedge clk_i) begin
      if (!rst_i && start_i && w_wb_writes) register[r_memwb_rd] <= w_wb_data;
    end
  end

  assign w_pc       = PC.pc_o;
  assign w_pc_plus4 = w_pc + 32'd4;
  assign w_if_instr = Instruction_Memory.memory[w_pc[9:2]];

  always_ff @(posedge clk_i) begin
    if (rst_i || (start_i && !w_stall && w_branch_taken)) begin
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
    end else if (start_i && !w_stall) begin
      r_ifid_pc    <= w_pc;
      r_ifid_instr <= w_if_instr;
    end
  end

  assign w_id_rs1    = r_ifid_instr[19:15];
  assign w_id_rs2    = r_ifid_instr[24:20];
  assign w_id_ctrl   = decode_ctrl(r_ifid_instr);
  assign w_id_is_beq = (r_ifid_instr[6:0] == OP_BRANCH) && (r_ifid_instr[14:12] == F3_BEQ);
  assign w_br_imm    = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                        r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
  assign w_br_target = r_ifid_pc + w_br_imm;
  assign w_wb_writes = r_memwb_reg_write && (r_memwb_rd != 5'd0);

  always_comb begin
    w_id_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
    if (r_ifid_instr[6:0] == OP_STORE)
      w_id_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
  end

  // Register read with same-cycle WB bypass; the branch compare uses these values.
  always_comb begin
    w_rd1 = Registers.register[w_id_rs1];
    w_rd2 = Registers.register[w_id_rs2];
    if (w_wb_writes && r_memwb_rd == w_id_rs1) w_rd1 = w_wb_data;
    if (w_wb_writes && r_memwb_rd == w_id_rs2) w_rd2 = w_wb_data;
    if (w_id_rs1 == 5'd0) w_rd1 = '0;
    if (w_id_rs2 == 5'd0) w_rd2 = '0;
  end

  assign w_branch_taken = w_id_is_beq && (w_rd1 == w_rd2) && !w_stall;

  cpu_hazard_forward_unit u_hazard_forward (
    .i_idex_mem_read   (r_idex_ctrl.mem_read),
    .i_idex_rd         (r_idex_rd),
    .i_idex_rs1        (r_idex_rs1),
    .i_idex_rs2        (r_idex_rs2),
    .i_id_rs1          (w_id_rs1),
    .i_id_rs2          (w_id_rs2),
    .i_exmem_reg_write (r_exmem_reg_write),
    .i_exmem_rd        (r_exmem_rd),
    .i_memwb_reg_write (r_memwb_reg_write),
    .i_memwb_rd        (r_memwb_rd),
    .o_stall           (w_stall),
    .o_fwd_a           (w_fwd_a),
    .o_fwd_b           (w_fwd_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || (start_i && w_stall)) begin
      r_idex_ctrl   <= '0;
      r_idex_rd1    <= '0;
      r_idex_rd2    <= '0;
      r_idex_imm    <= '0;
      r_idex_rs1    <= '0;
      r_idex_rs2    <= '0;
      r_idex_rd     <= '0;
      r_idex_funct3 <= '0;
      r_idex_funct7 <= '0;
    end else if (start_i) begin
      r_idex_ctrl   <= w_id_ctrl;
      r_idex_rd1    <= w_rd1;
      r_idex_rd2    <= w_rd2;
      r_idex_imm    <= w_id_imm;
      r_idex_rs1    <= w_id_rs1;
      r_idex_rs2    <= w_id_rs2;
      r_idex_rd     <= r_ifid_instr[11:7];
      r_idex_funct3 <= r_ifid_instr[14:12];
      r_idex_funct7 <= r_ifid_instr[31:25];
    end
  end

  always_comb begin
    case (w_fwd_a)
      FWD_EXMEM: w_op_a = r_exmem_alu;
      FWD_MEMWB: w_op_a = w_wb_data;
      default:   w_op_a = r_idex_rd1;
    endcase
    case (w_fwd_b)
      FWD_EXMEM: w_op_b = r_exmem_alu;
      FWD_MEMWB: w_op_b = w_wb_data;
      default:   w_op_b = r_idex_rd2;
    endcase
    w_alu_b    = r_idex_ctrl.alu_src ? r_idex_imm : w_op_b;
    w_alu_ctrl = alu_decode(r_idex_ctrl.alu_op, r_idex_funct3, r_idex_funct7);
    case (w_alu_ctrl)
      ALU_SUB: w_alu_result = w_op_a - w_alu_b;
      ALU_AND: w_alu_result = w_op_a & w_alu_b;
      ALU_XOR: w_alu_result = w_op_a ^ w_alu_b;
      ALU_SLL: w_alu_result = w_op_a << w_alu_b[4:0];
      ALU_SRA: w_alu_result = $signed(w_op_a) >>> w_alu_b[4:0];
`ifdef CPU_MUL_EN
      ALU_MUL: w_alu_result = w_op_a * w_alu_b;
`endif
      default: w_alu_result = w_op_a + w_alu_b;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_exmem_reg_write  <= 1'b0;
      r_exmem_mem_to_reg <= 1'b0;
      r_exmem_mem_write  <= 1'b0;
      r_exmem_alu        <= '0;
      r_exmem_store      <= '0;
      r_exmem_rd         <= '0;
    end else if (start_i) begin
      r_exmem_reg_write  <= r_idex_ctrl.reg_write;
      r_exmem_mem_to_reg <= r_idex_ctrl.mem_to_reg;
      r_exmem_mem_write  <= r_idex_ctrl.mem_write;
      r_exmem_alu        <= w_alu_result;
      r_exmem_store      <= w_op_b;
      r_exmem_rd         <= r_idex_rd;
    end
  end

  assign w_mem_rdata = Data_Memory.memory[r_exmem_alu[6:2]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_memwb_reg_write  <= 1'b0;
      r_memwb_mem_to_reg <= 1'b0;
      r_memwb_alu        <= '0;
      r_memwb_mem_data   <= '0;
      r_memwb_rd         <= '0;
    end else if (start_i) begin
      r_memwb_reg_write  <= r_exmem_reg_write;
      r_memwb_mem_to_reg <= r_exmem_mem_to_reg;
      r_memwb_alu        <= r_exmem_alu;
      r_memwb_mem_data   <= w_mem_rdata;
      r_memwb_rd         <= r_exmem_rd;
    end
  end

  assign w_wb_data = r_memwb_mem_to_reg ? r_memwb_mem_data : r_memwb_alu;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed program tests for the cpu pipeline with hand-computed register/memory results.
module tb_cpu;

  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  int n_total = 0;
  int n_bad   = 0;
  int reps, flushes;

  cpu dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rf(input int idx);
    return dut.Registers.register[idx];
  endfunction

  task automatic put(input int idx, input logic [31:0] instr);
    dut.Instruction_Memory.memory[idx] = instr;
  endtask

  // Hold reset and wipe program, data and registers so each test starts from known contents.
  task automatic begin_test();
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.Data_Memory.memory[i] = 32'h0;
    for (int i = 0; i < 32; i++) dut.Registers.register[i] = 32'h0;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b1;
  endtask

  // Runs n edges; a PC that repeats is a stall, a fetched non-nop that lands as a nop is a flush.
  task automatic run(input int n, output int n_reps, output int n_flush);
    logic [31:0] prev, cur, fetched;
    n_reps = 0;
    n_flush = 0;
    prev = dut.PC.pc_o;
    for (int i = 0; i < n; i++) begin
      fetched = dut.Instruction_Memory.memory[prev[9:2]];
      @(posedge clk);
      #1;
      cur = dut.PC.pc_o;
      if (cur == prev) n_reps++;
      else if (fetched != 32'h0 && dut.r_ifid_instr == 32'h0) n_flush++;
      prev = cur;
    end
  endtask

  initial begin
    // Load-use: lw then dependent addi costs exactly one stall.
    begin_test();
    dut.Data_Memory.memory[0] = 32'd5;
    put(0, i_type(12'd0, 5'd0, 3'b010, 5'd1, OP_LD));
    put(1, i_type(12'd3, 5'd1, 3'b000, 5'd2, OP_I));
    go();
    check("reset_pc", dut.PC.pc_o, 32'd0);
    check("reset_ifid", dut.r_ifid_instr, 32'd0);
    run(12, reps, flushes);
    check("lw_x1", rf(1), 32'd5);
    check("lw_use_x2", rf(2), 32'd8);
    check("lw_use_stalls", reps, 32'd1);

    // Back-to-back ALU forwarding, no stalls.
    begin_test();
    put(0, i_type(12'd7, 5'd0, 3'b000, 5'd1, OP_I));
    put(1, r_type(7'h00, 5'd1, 5'd1, 3'b000, 5'd2));
    put(2, r_type(7'h20, 5'd1, 5'd2, 3'b000, 5'd3));
    go();
    run(12, reps, flushes);
    check("fwd_add_x2", rf(2), 32'd14);
    check("fwd_sub_x3", rf(3), 32'd7);
    check("fwd_stalls", reps, 32'd0);

    // Taken beq skips the next instruction with one flush.
    begin_test();
    put(0, i_type(12'd4, 5'd0, 3'b000, 5'd1, OP_I));
    put(1, i_type(12'd4, 5'd0, 3'b000, 5'd2, OP_I));
    put(5, b_type(13'd8, 5'd2, 5'd1));
    put(6, i_type(12'd1, 5'd0, 3'b000, 5'd5, OP_I));
    put(7, i_type(12'd2, 5'd0, 3'b000, 5'd6, OP_I));
    go();
    run(16, reps, flushes);
    check("beq_taken_x5", rf(5), 32'd0);
    check("beq_taken_x6", rf(6), 32'd2);
    check("beq_taken_flush", flushes, 32'd1);

    // Not-taken beq falls through at no cost.
    begin_test();
    put(0, i_type(12'd4, 5'd0, 3'b000, 5'd1, OP_I));
    put(1, i_type(12'd3, 5'd0, 3'b000, 5'd2, OP_I));
    put(5, b_type(13'd8, 5'd2, 5'd1));
    put(6, i_type(12'd1, 5'd0, 3'b000, 5'd5, OP_I));
    put(7, i_type(12'd2, 5'd0, 3'b000, 5'd6, OP_I));
    go();
    run(16, reps, flushes);
    check("beq_fall_x5", rf(5), 32'd1);
    check("beq_fall_x6", rf(6), 32'd2);
    check("beq_fall_flush", flushes, 32'd0);
    check("beq_fall_stalls", reps, 32'd0);

    // Shifts and logic ops on negative values, all forwarded or bypassed.
    begin_test();
    put(0, i_type(12'hff0, 5'd0, 3'b000, 5'd1, OP_I));
    put(1, i_type(12'h402, 5'd1, 3'b101, 5'd2, OP_I));
    put(2, r_type(7'h00, 5'd2, 5'd1, 3'b100, 5'd3));
    put(3, r_type(7'h00, 5'd0, 5'd2, 3'b001, 5'd4));
    put(4, r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd5));
    put(5, r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd6));
    go();
    run(14, reps, flushes);
    check("srai_x2", rf(2), 32'hffff_fffc);
    check("xor_x3", rf(3), 32'd12);
    check("sll_x4", rf(4), 32'hffff_fffc);
    check("and_x5", rf(5), 32'hffff_fff0);
`ifdef CPU_MUL_EN
    check("mul_x6", rf(6), 32'd64);
`else
    check("mul_nop_x6", rf(6), 32'd0);
`endif

    // Store/load round trip, x0 write discarded, load data forwarded from MEM/WB.
    begin_test();
    put(0, i_type(12'd9, 5'd0, 3'b000, 5'd1, OP_I));
    put(1, s_type(12'd8, 5'd1, 5'd0));
    put(2, i_type(12'd8, 5'd0, 3'b010, 5'd2, OP_LD));
    put(3, i_type(12'd5, 5'd0, 3'b000, 5'd0, OP_I));
    put(4, r_type(7'h00, 5'd1, 5'd2, 3'b000, 5'd3));
    go();
    run(14, reps, flushes);
    check("sw_mem2", dut.Data_Memory.memory[2], 32'd9);
    check("lw_x2", rf(2), 32'd9);
    check("x0_zero", rf(0), 32'd0);
    check("ld_fwd_x3", rf(3), 32'd18);
    check("sw_lw_stalls", reps, 32'd0);

    // Mid-run reset: PC returns to 0, committed registers stay, the in-flight WB is dropped.
    begin_test();
    for (int i = 0; i < 16; i++) put(i, i_type(12'(i + 1), 5'd0, 3'b000, 5'(i + 8), OP_I));
    go();
    run(10, reps, flushes);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pc", dut.PC.pc_o, 32'd0);
    check("midrst_ifid", dut.r_ifid_instr, 32'd0);
    check("midrst_keep_x13", rf(13), 32'd6);
    check("midrst_drop_x14", rf(14), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    run(3, reps, flushes);
    check("hold_pc", dut.PC.pc_o, 32'd0);
    check("hold_reps", reps, 32'd3);
    start = 1'b1;
    run(24, reps, flushes);
    check("rerun_x14", rf(14), 32'd7);
    check("rerun_x23", rf(23), 32'd16);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
